// File: rtl/seq_det_sched.sv
// Round-robin time-shared serial pattern detector: one Moore detector core,
// per-channel shift/count contexts, registered match pulse and saturating total.
module seq_det_sched #(
  parameter int unsigned     NCH     = 4,
  parameter int unsigned     PLEN    = 4,
  parameter logic [PLEN-1:0] RST_PAT = 4'b1010,
  parameter logic            RST_OVL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           ch_req,
  input  logic [NCH-1:0]           ch_bit,
  output logic [NCH-1:0]           ch_gnt,
  input  logic                     cfg_we,
  input  logic [PLEN-1:0]          cfg_pat,
  input  logic                     cfg_ovl,
  output logic                     match_vld,
  output logic [$clog2(NCH)-1:0]   match_ch,
  output logic [15:0]              match_tot,
  output logic                     busy
);

  localparam int unsigned CW   = $clog2(NCH);
  localparam int unsigned CNTW = $clog2(PLEN + 1);
  localparam logic [CNTW:0]   PLEN_X = (CNTW + 1)'(PLEN);
  localparam logic [CNTW-1:0] PLEN_C = CNTW'(PLEN);

  logic [CW-1:0]   rr_ptr;
  logic [PLEN-1:0] pat;
  logic            ovl;
  logic [PLEN-1:0] shreg [NCH];
  logic [CNTW-1:0] cnt   [NCH];

  logic            gvld;
  logic [CW-1:0]   g;
  logic [CW-1:0]   g_next;
  logic [CW-1:0]   idx;
  int unsigned     k;
  logic [PLEN-1:0] s_new;
  logic [CNTW:0]   cnt_inc;
  logic [CNTW-1:0] c_new;
  logic            hit;

  assign busy = |ch_req;

  // Arbitration and next-context computation for the granted channel
  always_comb begin
    gvld    = 1'b0;
    g       = '0;
    idx     = '0;
    k       = 0;
    if (!rst && !cfg_we) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        k = 32'(rr_ptr) + i;
        if (k >= NCH) k = k - NCH;
        idx = CW'(k);
        if (!gvld && ch_req[idx]) begin
          gvld = 1'b1;
          g    = idx;
        end
      end
    end
    ch_gnt  = gvld ? (NCH'(1) << g) : '0;
    g_next  = (g == CW'(NCH - 1)) ? '0 : g + 1'b1;
    s_new   = {shreg[g][PLEN-2:0], ch_bit[g]};
    cnt_inc = {1'b0, cnt[g]} + 1'b1;
    c_new   = (cnt_inc >= PLEN_X) ? PLEN_C : cnt_inc[CNTW-1:0];
    hit     = gvld && (c_new == PLEN_C) && (s_new == pat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      pat       <= RST_PAT;
      ovl       <= RST_OVL;
      match_vld <= 1'b0;
      match_ch  <= '0;
      match_tot <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        shreg[i] <= '0;
        cnt[i]   <= '0;
      end
    end else if (cfg_we) begin
      pat       <= cfg_pat;
      ovl       <= cfg_ovl;
      match_vld <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        shreg[i] <= '0;
        cnt[i]   <= '0;
      end
    end else begin
      match_vld <= hit;
      if (gvld) begin
        rr_ptr   <= g_next;
        match_ch <= g;
        // Non-overlapping hit restarts the window; otherwise slide it
        if (hit && !ovl) begin
          shreg[g] <= '0;
          cnt[g]   <= '0;
        end else begin
          shreg[g] <= s_new;
          cnt[g]   <= c_new;
        end
        if (hit && (match_tot != 16'hFFFF)) match_tot <= match_tot + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed self-checking bench for seq_det_sched (NCH=4, PLEN=4, pat 1010).
module tb_seq_det_sched;

  logic       clk;
  logic       rst;
  logic [3:0] ch_req;
  logic [3:0] ch_bit;
  logic [3:0] ch_gnt;
  logic       cfg_we;
  logic [3:0] cfg_pat;
  logic       cfg_ovl;
  logic       match_vld;
  logic [1:0] match_ch;
  logic [15:0] match_tot;
  logic       busy;

  int total = 0;
  int bad   = 0;

  seq_det_sched #(
    .NCH(4), .PLEN(4), .RST_PAT(4'b1010), .RST_OVL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_bit(ch_bit), .ch_gnt(ch_gnt),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_ovl(cfg_ovl),
    .match_vld(match_vld), .match_ch(match_ch), .match_tot(match_tot), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One consuming cycle: drive, check comb grant, clock, check registered match
  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] bits,
                      input logic [3:0] egnt, input logic evld, input logic [1:0] ech);
    ch_req = req;
    ch_bit = bits;
    #1;
    chk({tag, ".gnt"}, 32'(ch_gnt), 32'(egnt));
    @(posedge clk);
    #1;
    chk({tag, ".vld"}, 32'(match_vld), 32'(evld));
    if (evld) chk({tag, ".ch"}, 32'(match_ch), 32'(ech));
    ch_req = '0;
    ch_bit = '0;
  endtask

  task automatic cfg(input string tag, input logic [3:0] p, input logic o, input logic [3:0] req);
    cfg_we  = 1'b1;
    cfg_pat = p;
    cfg_ovl = o;
    ch_req  = req;
    ch_bit  = 4'b1111;
    #1;
    chk({tag, ".gnt"}, 32'(ch_gnt), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, ".vld"}, 32'(match_vld), 32'd0);
    cfg_we = 1'b0;
    ch_req = '0;
    ch_bit = '0;
  endtask

  initial begin
    logic [5:0] s10;
    logic [4:0] s5;
    rst = 1'b1; ch_req = '0; ch_bit = '0; cfg_we = 1'b0; cfg_pat = '0; cfg_ovl = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.vld", 32'(match_vld), 32'd0);
    chk("rst.ch",  32'(match_ch),  32'd0);
    chk("rst.tot", 32'(match_tot), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    ch_req = 4'b0001; #1;
    chk("rst.gnt", 32'(ch_gnt), 32'd0);
    ch_req = '0;
    rst = 1'b0;

    // T1: non-overlapping, ch0 1,0,1,0,1,0 -> one hit after 4th bit
    s10 = 6'b101010;
    for (int i = 5; i >= 0; i--)
      step("t1", 4'b0001, {3'b000, s10[i]}, 4'b0001, (i == 2), 2'd0);
    chk("t1.tot", 32'(match_tot), 32'd1);

    // T2: overlapping mode, hits after bits 4 and 6
    cfg("t2.cfg", 4'b1010, 1'b1, 4'b0001);
    for (int i = 5; i >= 0; i--)
      step("t2", 4'b0001, {3'b000, s10[i]}, 4'b0001, (i == 2) || (i == 0), 2'd0);
    chk("t2.tot", 32'(match_tot), 32'd3);

    // T3: ch0+ch2 held; rr_ptr is 1 after ch0, so ch2 wins first
    ch_req = 4'b0101; #1;
    chk("t3.busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++)
      step("t3", 4'b0101, 4'b0000, (i % 2 == 0) ? 4'b0100 : 4'b0001, 1'b0, 2'd0);

    // T4: clear contexts, ch1/ch3 interleave 1,0,1,0 independently
    cfg("t4.cfg", 4'b1010, 1'b0, 4'b0000);
    s5 = 5'b01010;
    for (int i = 3; i >= 0; i--) begin
      step("t4a", 4'b1010, {s5[i], 1'b0, s5[i], 1'b0}, 4'b0010, (i == 0), 2'd1);
      step("t4b", 4'b1010, {s5[i], 1'b0, s5[i], 1'b0}, 4'b1000, (i == 0), 2'd3);
    end
    chk("t4.tot", 32'(match_tot), 32'd5);

    // T5: partial 1,0,1 lost on reconfigure to 0110
    step("t5", 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);
    step("t5", 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
    step("t5", 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);
    cfg("t5.cfg", 4'b0110, 1'b0, 4'b0001);
    s5 = 5'b00110;
    for (int i = 4; i >= 0; i--)
      step("t5b", 4'b0001, {3'b000, s5[i]}, 4'b0001, (i == 0), 2'd0);
    chk("t5.tot", 32'(match_tot), 32'd6);

    // T6: reset mid-pattern on ch2 wipes context and counters
    step("t6", 4'b0100, 4'b0100, 4'b0100, 1'b0, 2'd0);
    step("t6", 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0);
    step("t6", 4'b0100, 4'b0100, 4'b0100, 1'b0, 2'd0);
    chk("t6.ch_pre", 32'(match_ch), 32'd2);
    rst = 1'b1;
    ch_req = 4'b0100; #1;
    chk("t6.rst_gnt", 32'(ch_gnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ch_req = '0;
    chk("t6.vld", 32'(match_vld), 32'd0);
    chk("t6.ch",  32'(match_ch),  32'd0);
    chk("t6.tot", 32'(match_tot), 32'd0);
    step("t6b", 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0);
    chk("t6.tot2", 32'(match_tot), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
